// File: rtl/dram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dram_arbiter
//  Description : Two-master arbiter for the single-port data DRAM. The CPU
//                MEM-stage port has priority. A DMA/loader port is protected
//                from starvation by a saturating denial counter and may hold
//                the DRAM for a bounded locked burst. Read data (one-cycle
//                DRAM latency) is steered back to whichever port issued the
//                read.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n                    clock, asynchronous active-low reset
//    cpu_req_i/we_i/addr_i/wdata_i CPU access request (we == 0 is a read)
//    cpu_gnt_o, cpu_stall_o        CPU issued this cycle / CPU deferred
//    cpu_rvalid_o, cpu_rdata_o     CPU read return
//    dma_req_i/lock_i/we_i/addr_i/wdata_i  DMA access request (+ burst lock)
//    dma_gnt_o                     DMA issued this cycle
//    dma_rvalid_o, dma_rdata_o     DMA read return
//    dram_a_o/we_o/din_o           DRAM address, byte enables, write data
//    dram_spo_i                    DRAM read data (one cycle after address)
// ============================================================================
module dram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned MAX_BURST    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req_i,
    input  logic [3:0]  cpu_we_i,
    input  logic [15:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    output logic        cpu_gnt_o,
    output logic        cpu_stall_o,
    output logic        cpu_rvalid_o,
    output logic [31:0] cpu_rdata_o,
    input  logic        dma_req_i,
    input  logic        dma_lock_i,
    input  logic [3:0]  dma_we_i,
    input  logic [15:0] dma_addr_i,
    input  logic [31:0] dma_wdata_i,
    output logic        dma_gnt_o,
    output logic        dma_rvalid_o,
    output logic [31:0] dma_rdata_o,
    output logic [15:0] dram_a_o,
    output logic [3:0]  dram_we_o,
    output logic [31:0] dram_din_o,
    input  logic [31:0] dram_spo_i
);

    localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_LIMIT);
    // Beat counter value while the final permitted beat is being granted.
    localparam logic [3:0] C_BEAT_LAST  = 4'(MAX_BURST - 1);

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic [3:0]  beat_q, beat_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_dma_q, resp_dma_d;     // 1: outstanding read belongs to DMA

    logic        w_cpu_gnt;
    logic        w_dma_gnt;
    logic        w_burst_exit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_ARB;
            starve_q     <= 4'd0;
            beat_q       <= 4'd0;
            resp_valid_q <= 1'b0;
            resp_dma_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            beat_q       <= beat_d;
            resp_valid_q <= resp_valid_d;
            resp_dma_q   <= resp_dma_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        starve_d     = 4'd0;
        w_cpu_gnt    = 1'b0;
        w_dma_gnt    = 1'b0;
        w_burst_exit = 1'b0;

        case (state_q)
            ST_ARB: begin
                w_dma_gnt = dma_req_i & (~cpu_req_i | (starve_q == C_STARVE_MAX));
                w_cpu_gnt = cpu_req_i & ~w_dma_gnt;
                // The grant taken here already counts as beat 1.
                if (w_dma_gnt && dma_lock_i) begin
                    state_d = ST_BURST;
                    beat_d  = 4'd1;
                end
            end
            ST_BURST: begin
                w_dma_gnt    = dma_req_i;
                w_burst_exit = ~dma_req_i | ~dma_lock_i | (beat_q == C_BEAT_LAST);
                if (w_burst_exit) begin
                    state_d = ST_ARB;
                    beat_d  = 4'd0;
                end else begin
                    beat_d  = beat_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_ARB;
                beat_d  = 4'd0;
            end
        endcase

        // Saturating count of consecutive denied DMA cycles; a burst exit
        // also clears it so the CPU regains priority right after a burst.
        if (dma_req_i && !w_dma_gnt && !w_burst_exit) begin
            starve_d = (starve_q == C_STARVE_MAX) ? starve_q : starve_q + 4'd1;
        end
    end

    // Read tracking: one outstanding response, tagged with its owner.
    assign resp_valid_d = (w_dma_gnt & (dma_we_i == 4'd0)) |
                          (w_cpu_gnt & (cpu_we_i == 4'd0));
    assign resp_dma_d   = w_dma_gnt;

    assign cpu_gnt_o    = w_cpu_gnt;
    assign dma_gnt_o    = w_dma_gnt;
    assign cpu_stall_o  = cpu_req_i & ~w_cpu_gnt;

    assign cpu_rvalid_o = resp_valid_q & ~resp_dma_q;
    assign dma_rvalid_o = resp_valid_q &  resp_dma_q;
    assign cpu_rdata_o  = dram_spo_i;
    assign dma_rdata_o  = dram_spo_i;

    // Idle cycles still present the CPU address so a following CPU read
    // sees a stable bus, but never write.
    assign dram_a_o   = w_dma_gnt ? dma_addr_i  : cpu_addr_i;
    assign dram_din_o = w_dma_gnt ? dma_wdata_i : cpu_wdata_i;
    assign dram_we_o  = w_dma_gnt ? dma_we_i : (w_cpu_gnt ? cpu_we_i : 4'd0);

endmodule
`default_nettype wire

// File: tb/tb_dram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dram_arbiter
//  Description : Self-checking bench for dram_arbiter: table-driven vectors,
//                hand-written burst/reset sequences and randomized traffic
//                compared against a behavioural reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dram_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int MAX_BURST    = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req;
    logic [3:0]  cpu_we;
    logic [15:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_gnt, cpu_stall, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dma_req, dma_lock;
    logic [3:0]  dma_we;
    logic [15:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_gnt, dma_rvalid;
    logic [31:0] dma_rdata;
    logic [15:0] dram_a;
    logic [3:0]  dram_we;
    logic [31:0] dram_din;
    logic [31:0] dram_spo;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dram_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
        .cpu_wdata_i(cpu_wdata), .cpu_gnt_o(cpu_gnt), .cpu_stall_o(cpu_stall),
        .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata),
        .dma_req_i(dma_req), .dma_lock_i(dma_lock), .dma_we_i(dma_we),
        .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata), .dma_gnt_o(dma_gnt),
        .dma_rvalid_o(dma_rvalid), .dma_rdata_o(dma_rdata),
        .dram_a_o(dram_a), .dram_we_o(dram_we), .dram_din_o(dram_din),
        .dram_spo_i(dram_spo)
    );

    // ---------------- memory contents ----------------
    function automatic logic [31:0] init_val(input logic [15:0] a);
        case (a)
            16'h0010: init_val = 32'hDEADBEEF;
            16'h0020: init_val = 32'h20202020;
            16'h0030: init_val = 32'h30303030;
            16'h0040: init_val = 32'hAAAABBBB;
            16'hFFFF: init_val = 32'hFFFF0001;
            default:  init_val = {~a, a};
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = din[8*b +: 8];
        return r;
    endfunction

    // DRAM device model (synchronous read, byte-write).
    bit [31:0] dram_mem [65536];
    bit        dram_wr  [65536];

    function automatic logic [31:0] dram_rd(input logic [15:0] a);
        return dram_wr[a] ? dram_mem[a] : init_val(a);
    endfunction

    always @(posedge clk) begin
        dram_spo <= dram_rd(dram_a);
        if (dram_we != 4'd0) begin
            dram_mem[dram_a] <= merge(dram_rd(dram_a), dram_din, dram_we);
            dram_wr[dram_a]  <= 1'b1;
        end
    end

    // ---------------- reference model ----------------
    bit [31:0] exp_mem [65536];
    bit        exp_wr  [65536];
    bit        m_burst;
    int        m_denied;
    int        m_beats;
    bit        m_rv_c, m_rv_d;
    logic [31:0] m_rd_c, m_rd_d;

    function automatic logic [31:0] exp_rd(input logic [15:0] a);
        return exp_wr[a] ? exp_mem[a] : init_val(a);
    endfunction

    task automatic model_reset();
        m_burst = 0; m_denied = 0; m_beats = 0; m_rv_c = 0; m_rv_d = 0;
    endtask

    task automatic model_pred(output bit cg, output bit dg);
        if (m_burst) begin
            dg = dma_req;
            cg = 0;
        end else begin
            dg = dma_req && (!cpu_req || m_denied >= STARVE_LIMIT);
            cg = cpu_req && !dg;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        bit cg, dg;
        model_pred(cg, dg);
        chk("cpu_gnt",    32'(cpu_gnt),    32'(cg));
        chk("dma_gnt",    32'(dma_gnt),    32'(dg));
        chk("cpu_stall",  32'(cpu_stall),  32'(cpu_req && !cg));
        chk("dram_a",     32'(dram_a),     32'(dg ? dma_addr : cpu_addr));
        chk("dram_we",    32'(dram_we),    32'(dg ? dma_we : (cg ? cpu_we : 4'd0)));
        chk("dram_din",   dram_din,        dg ? dma_wdata : cpu_wdata);
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_rv_c));
        chk("dma_rvalid", 32'(dma_rvalid), 32'(m_rv_d));
        if (m_rv_c) chk("cpu_rdata", cpu_rdata, m_rd_c);
        if (m_rv_d) chk("dma_rdata", dma_rdata, m_rd_d);
    endtask

    task automatic model_update();
        bit cg, dg;
        model_pred(cg, dg);
        m_rv_c = cg && (cpu_we == 4'd0);
        m_rv_d = dg && (dma_we == 4'd0);
        m_rd_c = exp_rd(cpu_addr);
        m_rd_d = exp_rd(dma_addr);
        if (dg && dma_we != 0) begin
            exp_mem[dma_addr] = merge(exp_rd(dma_addr), dma_wdata, dma_we);
            exp_wr[dma_addr]  = 1;
        end else if (cg && cpu_we != 0) begin
            exp_mem[cpu_addr] = merge(exp_rd(cpu_addr), cpu_wdata, cpu_we);
            exp_wr[cpu_addr]  = 1;
        end
        if (m_burst) begin
            m_denied = 0;
            if (!dma_req || !dma_lock || m_beats + 1 >= MAX_BURST) begin
                m_burst = 0;
                m_beats = 0;
            end else begin
                m_beats++;
            end
        end else begin
            if (dg && dma_lock) begin
                m_burst = 1;
                m_beats = 1;
            end
            if (dma_req && !dg) m_denied = (m_denied + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_denied + 1;
            else                m_denied = 0;
        end
        if (!rst_n) model_reset();
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic to_neg();
        @(negedge clk);
        model_check();
    endtask

    task automatic to_next();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_lock = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    typedef struct {
        bit          creq;  logic [3:0] cwe; logic [15:0] ca; logic [31:0] cd;
        bit          dreq;  bit dlock; logic [3:0] dwe; logic [15:0] da; logic [31:0] dd;
        bit          ecg, edg, ecrv, edrv;
        logic [31:0] erd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit creq, logic [3:0] cwe, logic [15:0] ca, logic [31:0] cd,
                                bit dreq, logic [3:0] dwe, logic [15:0] da,
                                bit ecg, bit edg, bit ecrv, bit edrv, logic [31:0] erd);
        vec_t v;
        v.creq = creq; v.cwe = cwe; v.ca = ca; v.cd = cd;
        v.dreq = dreq; v.dlock = 0; v.dwe = dwe; v.da = da; v.dd = 32'h5A5A0000 | 32'(da);
        v.ecg = ecg; v.edg = edg; v.ecrv = ecrv; v.edrv = edrv; v.erd = erd;
        return v;
    endfunction

    initial begin
        // CPU read, routing, starvation, byte strobes, address 0xFFFF.
        vecs.push_back(mk(1, 4'h0, 16'h0010, 0, 0, 0, 0,            1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'h0, 16'h0000, 0, 0, 0, 0,            0, 0, 1, 0, 32'hDEADBEEF));
        vecs.push_back(mk(1, 4'h0, 16'h0020, 0, 0, 0, 0,            1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'h0, 16'h0000, 0, 1, 4'h0, 16'h0030,  0, 1, 1, 0, 32'h20202020));
        vecs.push_back(mk(0, 4'h0, 16'h0000, 0, 0, 0, 0,            0, 0, 0, 1, 32'h30303030));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 4'hF, 16'h0080, 1, 1, 4'hF, 16'h0090, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'hF, 16'h0080, 1, 1, 4'hF, 16'h0090, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 4'hF, 16'h0080, 1, 1, 4'hF, 16'h0090, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'h0, 16'h0000, 0, 0, 0, 0,            0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'h3, 16'h0040, 32'h11112222, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 4'h0, 16'h0040, 0, 0, 0, 0,            1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'h0, 16'h0000, 0, 0, 0, 0,            0, 0, 1, 0, 32'hAAAA2222));
        vecs.push_back(mk(0, 4'h0, 16'h0000, 0, 1, 4'h0, 16'hFFFF,  0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 4'h0, 16'h0000, 0, 0, 0, 0,            0, 0, 0, 1, 32'hFFFF0001));
        vecs.push_back(mk(1, 4'h0, 16'hFFFF, 0, 1, 4'h0, 16'h0010,  1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'h0, 16'h0000, 0, 0, 0, 0,            0, 0, 1, 0, 32'hFFFF0001));

        idle();
        rst_n = 0;
        model_reset();
        #2;
        chk("reset_cpu_rvalid", 32'(cpu_rvalid), 0);
        chk("reset_dma_rvalid", 32'(dma_rvalid), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1;

        // ---- table-driven vectors ----
        foreach (vecs[i]) begin
            cpu_req = vecs[i].creq; cpu_we = vecs[i].cwe; cpu_addr = vecs[i].ca; cpu_wdata = vecs[i].cd;
            dma_req = vecs[i].dreq; dma_lock = vecs[i].dlock; dma_we = vecs[i].dwe;
            dma_addr = vecs[i].da; dma_wdata = vecs[i].dd;
            to_neg();
            chk($sformatf("vec%0d_cpu_gnt", i),    32'(cpu_gnt),    32'(vecs[i].ecg));
            chk($sformatf("vec%0d_dma_gnt", i),    32'(dma_gnt),    32'(vecs[i].edg));
            chk($sformatf("vec%0d_cpu_rvalid", i), 32'(cpu_rvalid), 32'(vecs[i].ecrv));
            chk($sformatf("vec%0d_dma_rvalid", i), 32'(dma_rvalid), 32'(vecs[i].edrv));
            if (vecs[i].ecrv) chk($sformatf("vec%0d_cpu_rdata", i), cpu_rdata, vecs[i].erd);
            if (vecs[i].edrv) chk($sformatf("vec%0d_dma_rdata", i), dma_rdata, vecs[i].erd);
            to_next();
        end

        // ---- locked burst after starvation, CPU held high ----
        do_reset();
        cpu_req = 1; cpu_we = 4'hF; cpu_addr = 16'h0050; cpu_wdata = 32'h0C0C0C0C;
        dma_req = 1; dma_lock = 1; dma_we = 4'hF; dma_addr = 16'h0100; dma_wdata = 32'hB0000000;
        for (int i = 0; i < STARVE_LIMIT; i++) begin
            to_neg(); chk("starve_cpu_gnt", 32'(cpu_gnt), 1); to_next();
        end
        for (int k = 0; k < MAX_BURST; k++) begin
            dma_addr = 16'h0100 + 16'(k); dma_wdata = 32'hB0000000 + 32'(k);
            to_neg();
            chk("burst_dma_gnt", 32'(dma_gnt), 1);
            chk("burst_cpu_stall", 32'(cpu_stall), 1);
            to_next();
        end
        to_neg();
        chk("post_burst_cpu_gnt", 32'(cpu_gnt), 1);
        chk("post_burst_dma_gnt", 32'(dma_gnt), 0);
        to_next();
        idle(); to_neg(); to_next();
        for (int k = 0; k < MAX_BURST; k++)
            chk("burst_mem", dram_rd(16'h0100 + 16'(k)), 32'hB0000000 + 32'(k));

        // ---- early lock drop on beat 3 ----
        do_reset();
        dma_req = 1; dma_lock = 1; dma_we = 4'hF; dma_addr = 16'h0200; dma_wdata = 32'h77;
        to_neg(); chk("lock_beat1", 32'(dma_gnt), 1); to_next();
        cpu_req = 1; cpu_we = 4'hF; cpu_addr = 16'h0060; dma_addr = 16'h0201;
        to_neg(); chk("lock_beat2", 32'(dma_gnt), 1); to_next();
        dma_lock = 0; dma_addr = 16'h0202;
        to_neg(); chk("lock_beat3", 32'(dma_gnt), 1); chk("lock_beat3_stall", 32'(cpu_stall), 1); to_next();
        to_neg(); chk("lockdrop_cpu_gnt", 32'(cpu_gnt), 1); chk("lockdrop_dma_gnt", 32'(dma_gnt), 0); to_next();

        // ---- reset during beat 4 with a DMA read in flight ----
        do_reset();
        dma_req = 1; dma_lock = 1; dma_we = 4'h0; dma_addr = 16'h0010;
        to_neg(); to_next();
        cpu_req = 1; cpu_we = 4'h0; cpu_addr = 16'h0020; dma_addr = 16'h0011;
        to_neg(); to_next();
        dma_addr = 16'h0012;
        to_neg(); to_next();
        dma_addr = 16'h0013;
        to_neg();
        chk("midburst_rvalid_before", 32'(dma_rvalid), 1);
        #1 rst_n = 0;
        model_reset();
        #1;
        chk("rst_dma_rvalid", 32'(dma_rvalid), 0);
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
        chk("rst_cpu_gnt",    32'(cpu_gnt), 1);
        chk("rst_dma_gnt",    32'(dma_gnt), 0);
        @(posedge clk); #1;
        rst_n = 1;
        to_neg();
        chk("release_cpu_first", 32'(cpu_gnt), 1);
        chk("release_dma_gnt",   32'(dma_gnt), 0);
        chk("release_no_rvalid", 32'(dma_rvalid), 0);
        to_next();
        to_neg(); chk("inflight_never_returns", 32'(dma_rvalid), 0); to_next();

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 3000; n++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            if (!rst_n) model_reset();
            cpu_req   = ($urandom_range(0, 99) < 60);
            cpu_we    = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
            cpu_addr  = 16'($urandom_range(0, 15));
            cpu_wdata = $urandom;
            dma_req   = ($urandom_range(0, 99) < 75);
            dma_lock  = ($urandom_range(0, 99) < 60);
            dma_we    = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
            dma_addr  = 16'($urandom_range(0, 15));
            dma_wdata = $urandom;
            to_neg();
            to_next();
        end
        rst_n = 1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dram_arbiter.md
# dram_arbiter

Shares the single-port data DRAM between the CPU MEM-stage load/store unit and a secondary DMA/loader master. Each cycle it selects one access and drives the DRAM address, byte-strobe and write-data lines. It routes the one-cycle-latency read data back to the requester that issued the read, and raises a stall toward the hazard unit whenever the CPU's access is deferred. CPU accesses have priority. A starvation limit and a bounded locked-burst mode keep the DMA port making progress without blocking the pipeline indefinitely.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive denied DMA cycles after which DMA wins over CPU (range 1..15).
- MAX_BURST, 8: maximum beats in one locked DMA burst (range 2..16).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- cpu_req  in  1  CPU access request (MEM stage, valid load/store).
- cpu_we  in  4  CPU byte strobes; 0 means read.
- cpu_addr  in  16  CPU word address.
- cpu_wdata  in  32  CPU store data, already lane-aligned.
- cpu_gnt  out  1  CPU access issued to DRAM this cycle.
- cpu_stall  out  1  cpu_req & ~cpu_gnt.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  32  CPU read data.
- dma_req  in  1  DMA access request.
- dma_lock  in  1  DMA requests a locked burst.
- dma_we  in  4  DMA byte strobes; 0 means read.
- dma_addr  in  16  DMA word address.
- dma_wdata  in  32  DMA write data.
- dma_gnt  out  1  DMA access issued this cycle.
- dma_rvalid  out  1  DMA read data valid.
- dma_rdata  out  32  DMA read data.
- dram_a  out  16  DRAM word address.
- dram_we  out  4  DRAM byte write enables.
- dram_din  out  32  DRAM write data.
- dram_spo  in  32  DRAM read data, valid one cycle after the address.

## Operation
- FSM states: ARB (reset state) and BURST.
- ARB grant rule, combinational and same-cycle:
  - dma_gnt = dma_req & (~cpu_req | starve_cnt == STARVE_LIMIT).
  - cpu_gnt = cpu_req & ~dma_gnt.
- BURST grant rule: dma_gnt = dma_req; cpu_gnt = 0.
- starve_cnt (4 bits):
  - increments, saturating at STARVE_LIMIT, on dma_req & ~dma_gnt;
  - clears when ~dma_req or dma_gnt.
- ARB -> BURST: on dma_gnt & dma_lock. beat_cnt is loaded with 1, because the ARB-cycle grant is beat 1.
- In BURST, each dma_gnt increments beat_cnt.
- BURST -> ARB at the end of a cycle in which any of these holds:
  - ~dma_req;
  - dma_gnt & ~dma_lock (this grant is the final beat);
  - dma_gnt & beat_cnt == MAX_BURST-1 (this grant is beat MAX_BURST).
- Burst exit clears starve_cnt and beat_cnt, so the first ARB cycle after a burst gives the CPU priority.
- DRAM drive:
  - Granted requester's addr/we/wdata pass through combinationally.
  - With no grant: dram_a = cpu_addr, dram_we = 0, dram_din = cpu_wdata.
- Read tracking:
  - A granted access with we == 0 registers resp_valid = 1 and resp_owner = the granted port.
  - Next cycle, that port's rvalid = 1; the other port's rvalid = 0.
  - Both rdata outputs = dram_spo combinationally; they are meaningful only when the matching rvalid is set.
- Write accesses produce no rvalid.
- Address wrap: the 16-bit address passes through unmodified; no range check.

## Timing
- Grant-to-DRAM latency: 0 cycles. Write committed at the grant cycle's clock edge.
- Read latency: rvalid exactly 1 cycle after the grant. Back-to-back reads give back-to-back rvalid.
- A CPU request that is stalled must be held stable by the pipeline until cpu_gnt; the arbiter does not buffer requests.
- Worst-case CPU wait: MAX_BURST cycles, while a locked burst runs.
- Worst-case DMA wait outside a burst: STARVE_LIMIT cycles.
- Reset values (asynchronous, including mid-burst):
  - Registered state: state = ARB, starve_cnt = 0, beat_cnt = 0, resp_valid = 0.
  - cpu_rvalid = dma_rvalid = 0.
  - Grants and dram_we follow the combinational rules with state = ARB.
- A read in flight at reset assertion never returns rvalid.
- Release from reset: the first edge with rst_n high behaves as ARB with zero counters.

## Test plan
- CPU only: cpu_req read at addr 0x0010 with DRAM[0x10] = 0xDEADBEEF -> cpu_gnt = 1 the same cycle, cpu_rvalid = 1 with cpu_rdata = 0xDEADBEEF next cycle, dma_rvalid = 0.
- Starvation: cpu_req and dma_req held high, STARVE_LIMIT = 4 -> cpu_gnt on cycles 0-3 and dma_gnt on cycle 4 with cpu_stall = 1; cpu_gnt resumes on cycle 5, after which the 5-cycle pattern repeats.
- Locked burst: dma_lock = 1 with writes to 0x0100.., MAX_BURST = 8, cpu_req high -> exactly 8 consecutive dma_gnt, cpu_stall = 1 for those 8 cycles, then cpu_gnt on the next cycle; DRAM contents match the 8 writes.
- Early lock drop: dma_lock deasserted on beat 3 -> that beat is granted, then state = ARB and a waiting CPU is granted the next cycle.
- Mixed read routing: CPU read 0x0020 in cycle n, DMA read 0x0030 in cycle n+1 -> cpu_rvalid in n+1 and dma_rvalid in n+2, each returning its own DRAM word; no cross-delivery.
- Reset mid-burst: rst_n low during beat 4 of a burst that also has a read in flight -> rvalid outputs drop immediately and no rvalid is ever returned for the in-flight read; state = ARB after release, and the CPU is granted before the DMA when both request.
